wm8731_i2c_writer: RTL and testbench
====================================

# wm8731_i2c_writer

Single-master, write-only I2C engine driving the WM8731 control port (AUD_SCLK/AUD_SDAT on DE2-115). It sits directly downstream of the codec register-configuration sequencer. It accepts one 16-bit control word (7-bit register address plus 9-bit value) per transaction and sends it as a 3-byte I2C write: device address, then high byte, then low byte. It reports completion and ACK failures back to the sequencer.

## Interface
Parameters:
- QDIV, 125: MCLK cycles per SCL quarter-period. At 50 MHz this gives 100 kHz SCL. Legal range 2..1023.
- DEV_ADDR, 7'h1A: 7-bit codec address (CSB low). R/W bit is always 0.

Ports:
- MCLK  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-low reset.
- ENABLE  in  1  level request. Sampled only in IDLE after the bus-free time has elapsed.
- DATA  in  16  control word {reg_addr[6:0], value[8:0]}. Latched on transaction accept.
- BUSY  out  1  high from accept until FINISHED is asserted.
- FINISHED  out  1  one-cycle pulse at the end of every transaction, including aborted ones.
- ACK_ERR  out  1  high if any ACK slot of the last transaction read high. Updated with FINISHED.
- AUD_SCLK  out  1  SCL. Push-pull: the codec never stretches the clock.
- SDA_OE  out  1  1 = pull SDA low. 0 = release. The top level builds the tristate.
- SDA_IN  in  1  SDA pin readback, passed through a 2-flop synchronizer internally.

## Operation
- Quarter tick: free-running counter 0..QDIV-1. A tick fires on terminal count. The counter is cleared on accept, so phases align to the start of the transaction.
- Every bus phase lasts 4 ticks, q0..q3.
- FSM states: IDLE, START, BIT, ACK, STOP, GAP.
- **IDLE**: SCL=1, SDA released. If ENABLE=1, then on the next edge:
  - latch DATA into shreg[23:0] = {DEV_ADDR, 1'b0, DATA};
  - set BUSY;
  - go to START.
- **START**:
  - q0: SCL=1, SDA=1.
  - q1: SDA=0.
  - q2, q3: SCL=0, SDA=0.
  - Then go to BIT with bit count 7.
- **BIT** (MSB first):
  - q0: SCL=0, SDA=shreg[23].
  - q1, q2: SCL=1.
  - q3: SCL=0.
  - At the end of q3, shift shreg left by 1. Go to ACK after the 8th bit of a byte.
- **ACK**:
  - SDA released in all quarters. SCL follows the same pattern as BIT.
  - Sample synchronized SDA_IN at the q1→q2 tick. Low means ACK.
  - On ACK: after byte 0 or 1 go to BIT; after byte 2 go to STOP.
  - On NACK: set the error flag and go to STOP immediately; remaining bytes are skipped.
- **STOP**:
  - q0: SCL=0, SDA=0.
  - q1: SCL=1, SDA=0.
  - q2, q3: SCL=1, SDA released.
  - At the end of q3, pulse FINISHED, drive ACK_ERR from the error flag, clear BUSY, and go to GAP.
- **GAP**: bus free for 4 ticks, then go to IDLE.
  - ENABLE is ignored in GAP, so the sequencer has time to update DATA on the FINISHED edge.
- ENABLE and DATA changes while BUSY have no effect.
- ENABLE held high continuously gives back-to-back transactions separated only by GAP.

## Timing
- Successful transaction:
  - 29 phases × 4 ticks = 116·QDIV cycles from accept to FINISHED.
  - Next accept happens at the earliest 4·QDIV+1 cycles after FINISHED.
- NACK on byte n (n = 0, 1, 2): (1 + 9(n+1) + 1)·4·QDIV cycles to FINISHED.
- SCL high time is 2·QDIV cycles. SDA changes only in q0 while SCL is low, except for the START and STOP edges.
- Reset values: AUD_SCLK=1, SDA_OE=0, BUSY=0, FINISHED=0, ACK_ERR=0, state=IDLE, tick counter=0.
- Reset mid-transaction releases the bus asynchronously. No STOP is generated; the codec resynchronizes on the next START.
- Simultaneous RESET deassertion and ENABLE=1: the first accept occurs on the first clock edge after RESET goes high.

## Structure
- Package wm8731_pkg holds:
  - the state enum;
  - the WM8731 default device address;
  - byte and transaction-length constants (BITS_PER_BYTE=8, NUM_BYTES=3, QUARTERS=4).
- Sub-module i2c_qtick: parameterized quarter-tick divider with a synchronous clear. Ports: MCLK, RESET, CLR, TICK.
- Top file contains the FSM, the 24-bit shift register, a 2-bit byte counter, a 3-bit bit counter, and the SDA_IN synchronizer.

## Test plan
All scenarios use QDIV=4.
- Reset, then ENABLE=1 with DATA=16'h0E53:
  - SDA carries 0x34, ACK, 0x0E, ACK, 0x53, ACK, STOP;
  - FINISHED pulses 464 cycles after accept;
  - ACK_ERR=0.
- Slave model NACKs the address byte, DATA=16'h1201: STOP follows immediately, FINISHED at 11·16 = 176 cycles, ACK_ERR=1.
- ENABLE held high, DATA advancing 0..9 on each FINISHED edge:
  - ten transactions, each carrying the DATA value present at its accept;
  - each next START begins ≥16 cycles after the preceding FINISHED.
- DATA toggled and ENABLE dropped mid-transaction: the transmitted bytes match the value latched at accept, and one FINISHED pulse occurs.
- RESET asserted during byte 1: AUD_SCLK=1, SDA_OE=0 and BUSY=0 within the same cycle; no FINISHED pulse; the next ENABLE produces a clean full transaction.
- Protocol checker over all tests:
  - SDA never changes while SCL is high, except at START and STOP;
  - SCL high time = 8 cycles.

Source files
------------

// File: rtl/wm8731_pkg.sv
// wm8731_pkg: shared types and constants for the WM8731 control-port I2C writer.
//   state_t    - writer FSM states
//   bus_drv_t  - SCL / SDA pull-down drive pair for one quarter of a bus phase
//   bus_drive  - waveform table: maps (state, quarter, data bit) to bus drive
package wm8731_pkg;

  localparam int BITS_PER_BYTE = 8;
  localparam int NUM_BYTES     = 3;   // device address, high byte, low byte
  localparam int QUARTERS      = 4;   // ticks per bus phase

  // WM8731 with CSB tied low
  localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;

  localparam logic [1:0] Q_LAST = 2'(QUARTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_GAP
  } state_t;

  typedef struct packed {
    logic scl;
    logic sda_oe;   // 1 = pull SDA low
  } bus_drv_t;

  // SDA only moves in q0 while SCL is low, except the START fall (q1) and the
  // STOP rise (q2), which happen with SCL high.
  function automatic bus_drv_t bus_drive(input state_t st, input logic [1:0] q,
                                         input logic bit_val);
    bus_drv_t d;
    d.scl    = 1'b1;
    d.sda_oe = 1'b0;
    case (st)
      S_START: begin
        d.scl    = (q < 2'd2);
        d.sda_oe = (q != 2'd0);
      end
      S_BIT: begin
        d.scl    = (q == 2'd1) || (q == 2'd2);
        d.sda_oe = ~bit_val;
      end
      S_ACK: begin
        d.scl    = (q == 2'd1) || (q == 2'd2);
        d.sda_oe = 1'b0;
      end
      S_STOP: begin
        d.scl    = (q != 2'd0);
        d.sda_oe = (q < 2'd2);
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: quarter-period tick divider for the I2C writer.
//   MCLK  - system clock
//   RESET - async active-low reset
//   CLR   - synchronous clear; realigns phases to a new transaction
//   TICK  - high for one cycle when the counter reaches QDIV-1
module i2c_qtick #(
  parameter int QDIV = 125
) (
  input  logic MCLK,
  input  logic RESET,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] TC = CW'(QDIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET)                cnt <= '0;
    else if (CLR || cnt == TC) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

  assign TICK = (cnt == TC);

endmodule

// File: rtl/wm8731_i2c_writer.sv
// wm8731_i2c_writer: write-only single-master I2C engine for the WM8731
// control port. Sends {DEV_ADDR,W}, DATA[15:8], DATA[7:0] per transaction.
//   MCLK, RESET      - clock, async active-low reset
//   ENABLE, DATA     - level request and control word {reg[6:0], val[8:0]}
//   BUSY             - accept .. FINISHED
//   FINISHED         - 1-cycle end-of-transaction pulse (also on NACK abort)
//   ACK_ERR          - some ACK slot of the last transaction read high
//   AUD_SCLK, SDA_OE - push-pull SCL, SDA pull-down enable
//   SDA_IN           - SDA pin readback (asynchronous)
module wm8731_i2c_writer
  import wm8731_pkg::*;
#(
  parameter int         QDIV     = 125,
  parameter logic [6:0] DEV_ADDR = WM8731_DEV_ADDR
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [15:0] DATA,
  output logic        BUSY,
  output logic        FINISHED,
  output logic        ACK_ERR,
  output logic        AUD_SCLK,
  output logic        SDA_OE,
  input  logic        SDA_IN
);

  state_t      state;
  logic [1:0]  q;
  logic [23:0] shreg;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic        err;
  logic [1:0]  sda_sync;
  logic        tick;
  logic        accept;
  bus_drv_t    drv;

  assign accept = (state == S_IDLE) && ENABLE;

  i2c_qtick #(.QDIV(QDIV)) u_qtick (
    .MCLK  (MCLK),
    .RESET (RESET),
    .CLR   (accept),
    .TICK  (tick)
  );

  // Released bus reads high, so the synchronizer resets to 1s.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) sda_sync <= 2'b11;
    else        sda_sync <= {sda_sync[0], SDA_IN};
  end

  assign drv = bus_drive(state, q, shreg[23]);

  // Bus pins are registered from the decoded drive, so they trail the
  // state/quarter registers by one cycle; all edges shift together.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      q        <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      err      <= 1'b0;
      BUSY     <= 1'b0;
      FINISHED <= 1'b0;
      ACK_ERR  <= 1'b0;
      AUD_SCLK <= 1'b1;
      SDA_OE   <= 1'b0;
    end else begin
      FINISHED <= 1'b0;
      AUD_SCLK <= drv.scl;
      SDA_OE   <= drv.sda_oe;
      if (state == S_IDLE) begin
        if (ENABLE) begin
          shreg    <= {DEV_ADDR, 1'b0, DATA};
          BUSY     <= 1'b1;
          err      <= 1'b0;
          q        <= '0;
          byte_cnt <= '0;
          state    <= S_START;
        end
      end else if (tick) begin
        q <= q + 2'd1;
        case (state)
          S_START: if (q == Q_LAST) begin
            state   <= S_BIT;
            bit_cnt <= 3'(BITS_PER_BYTE - 1);
          end
          S_BIT: if (q == Q_LAST) begin
            shreg <= {shreg[22:0], 1'b0};
            if (bit_cnt == 3'd0) state <= S_ACK;
            else                 bit_cnt <= bit_cnt - 3'd1;
          end
          S_ACK: begin
            // sample mid SCL-high; a high line is a NACK
            if (q == 2'd1 && sda_sync[1]) err <= 1'b1;
            if (q == Q_LAST) begin
              if (err || byte_cnt == 2'(NUM_BYTES - 1)) begin
                state <= S_STOP;
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
                bit_cnt  <= 3'(BITS_PER_BYTE - 1);
                state    <= S_BIT;
              end
            end
          end
          S_STOP: if (q == Q_LAST) begin
            FINISHED <= 1'b1;
            ACK_ERR  <= err;
            BUSY     <= 1'b0;
            state    <= S_GAP;
          end
          // bus-free time; ENABLE is deliberately not looked at here
          S_GAP: if (q == Q_LAST) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wm8731_i2c_writer.sv
// tb_wm8731_i2c_writer: scoreboard bench. Stimulus pushes expected bytes and
// end-of-transaction results; an I2C slave/monitor pops and compares them and
// checks SDA stability while SCL is high and the SCL high time.
module tb_wm8731_i2c_writer;

  localparam int Q = 4;

  logic        MCLK;
  logic        RESET;
  logic        ENABLE;
  logic [15:0] DATA;
  logic        BUSY, FINISHED, ACK_ERR, AUD_SCLK, SDA_OE, SDA_IN;

  logic slv_pull = 1'b0;
  assign SDA_IN = ~SDA_OE & ~slv_pull;

  wm8731_i2c_writer #(.QDIV(Q)) dut (
    .MCLK     (MCLK),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .DATA     (DATA),
    .BUSY     (BUSY),
    .FINISHED (FINISHED),
    .ACK_ERR  (ACK_ERR),
    .AUD_SCLK (AUD_SCLK),
    .SDA_OE   (SDA_OE),
    .SDA_IN   (SDA_IN)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { logic err; int lat; } fin_t;
  logic [7:0] exp_bytes[$];
  fin_t       exp_fin[$];
  int         nack_byte = -1;

  task automatic push_txn(input logic [15:0] d, input int nack);
    logic [7:0] a;
    fin_t f;
    a = {7'h1A, 1'b0};
    exp_bytes.push_back(a);
    if (nack != 0) begin
      exp_bytes.push_back(d[15:8]);
      if (nack != 1) exp_bytes.push_back(d[7:0]);
    end
    f.err = (nack >= 0);
    f.lat = (nack < 0) ? 116 * Q : (2 + 9 * (nack + 1)) * 4 * Q;
    exp_fin.push_back(f);
  endtask

  // ---------------- slave / monitor ----------------
  int   cyc = 0;
  always @(posedge MCLK) cyc <= cyc + 1;

  logic scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0;
  logic in_xfer = 1'b0, ack_clk = 1'b0, meas = 1'b0, have_fin = 1'b0;
  logic sda_v;
  logic [7:0] sh;
  int bitn = 0, byte_i = 0, hi_cnt = 0, acc_cyc = 0, fin_cyc = 0, fin_cnt = 0;

  always @(negedge MCLK) begin
    fin_t e;
    sda_v = ~SDA_OE & ~slv_pull;
    if (!RESET) begin
      in_xfer = 1'b0; bitn = 0; ack_clk = 1'b0; meas = 1'b0; slv_pull = 1'b0;
    end else begin
      if (BUSY && !busy_p) acc_cyc = cyc;
      if (FINISHED) begin
        fin_cnt++; fin_cyc = cyc; have_fin = 1'b1;
        if (exp_fin.size() == 0) chk("fin_unexpected", 1, 0);
        else begin
          e = exp_fin.pop_front();
          chk("ack_err", ACK_ERR, e.err);
          chk("latency", cyc - acc_cyc, e.lat);
          chk("busy_clr", BUSY, 0);
        end
      end
      if (scl_p && AUD_SCLK && sda_v != sda_p) begin
        if (!sda_v) begin            // START
          chk("start_idle", in_xfer, 0);
          if (have_fin) chk("gap_ge16", (cyc - fin_cyc) >= 16, 1);
          in_xfer = 1'b1; bitn = 0; byte_i = 0; ack_clk = 1'b0;
        end else begin               // STOP: only after the STOP phase SCL rise
          chk("stop_pos", in_xfer && bitn == 1 && !ack_clk, 1);
          in_xfer = 1'b0; meas = 1'b0;
        end
      end else if (!scl_p && AUD_SCLK && in_xfer) begin
        meas = 1'b1; hi_cnt = 0;
        if (bitn < 8) begin
          sh = {sh[6:0], sda_v};
          bitn++;
          if (bitn == 8) begin
            if (exp_bytes.size() == 0) chk("byte_unexpected", 1, 0);
            else chk("byte", sh, exp_bytes.pop_front());
          end
        end else begin
          bitn = 0; ack_clk = 1'b1; byte_i++;
        end
      end else if (scl_p && !AUD_SCLK) begin
        if (meas) chk("scl_high", hi_cnt, 2 * Q);
        meas = 1'b0;
        if (ack_clk) begin
          slv_pull = 1'b0; ack_clk = 1'b0;
        end else if (in_xfer && bitn == 8) begin
          slv_pull = (byte_i != nack_byte);
        end
      end
      if (AUD_SCLK && meas) hi_cnt++;
    end
    scl_p  = AUD_SCLK;
    sda_p  = ~SDA_OE & ~slv_pull;
    busy_p = BUSY;
  end

  // ---------------- stimulus ----------------
  task automatic wait_busy(input int bound);
    int n = 0;
    do begin @(negedge MCLK); n++; end while (!BUSY && n < bound);
    chk("busy_wait", BUSY, 1);
  endtask

  task automatic wait_fin(input int bound);
    int n = 0;
    do begin @(negedge MCLK); n++; end while (!FINISHED && n < bound);
    chk("fin_wait", FINISHED, 1);
  endtask

  int f0;

  initial begin
    RESET = 1'b0; ENABLE = 1'b0; DATA = '0;
    repeat (3) @(negedge MCLK);
    chk("rst_scl", AUD_SCLK, 1);
    chk("rst_oe", SDA_OE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_fin", FINISHED, 0);
    chk("rst_ackerr", ACK_ERR, 0);

    // 1: plain write, ENABLE already high as reset releases
    DATA = 16'h0E53; ENABLE = 1'b1; push_txn(16'h0E53, -1);
    #2 RESET = 1'b1;
    @(negedge MCLK);
    chk("first_accept", BUSY, 1);
    ENABLE = 1'b0;
    wait_fin(600);
    repeat (20) @(negedge MCLK);
    chk("t1_q_empty", exp_bytes.size(), 0);

    // 2: address NACK
    nack_byte = 0;
    DATA = 16'h1201; push_txn(16'h1201, 0); ENABLE = 1'b1;
    wait_busy(5); ENABLE = 1'b0;
    wait_fin(300);
    repeat (20) @(negedge MCLK);
    chk("t2_q_empty", exp_bytes.size(), 0);
    nack_byte = -1;

    // 3: back-to-back with ENABLE held, DATA advanced on FINISHED
    f0 = fin_cnt;
    DATA = 16'd0; push_txn(16'd0, -1); ENABLE = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_fin(600);
      if (k < 9) begin
        DATA = 16'(k + 1); push_txn(16'(k + 1), -1);
      end else ENABLE = 1'b0;
    end
    repeat (30) @(negedge MCLK);
    chk("t3_count", fin_cnt - f0, 10);
    chk("t3_q_empty", exp_bytes.size(), 0);

    // 4: DATA/ENABLE churn while busy
    f0 = fin_cnt;
    DATA = 16'hA5C3; push_txn(16'hA5C3, -1); ENABLE = 1'b1;
    wait_busy(5);
    for (int i = 0; i < 40; i++) begin
      @(negedge MCLK);
      DATA = 16'($urandom);
      ENABLE = 1'($urandom_range(0, 1));
    end
    ENABLE = 1'b0;
    wait_fin(600);
    repeat (40) @(negedge MCLK);
    chk("t4_one_fin", fin_cnt - f0, 1);
    chk("t4_q_empty", exp_bytes.size(), 0);

    // 5: reset during byte 1, then a clean transaction
    DATA = 16'h3C96; exp_bytes.push_back(8'h34); ENABLE = 1'b1;
    wait_busy(5); ENABLE = 1'b0;
    repeat (200) @(negedge MCLK);
    f0 = fin_cnt;
    #2 RESET = 1'b0;
    #1;
    chk("abort_scl", AUD_SCLK, 1);
    chk("abort_oe", SDA_OE, 0);
    chk("abort_busy", BUSY, 0);
    repeat (3) @(negedge MCLK);
    chk("t5_addr_seen", exp_bytes.size(), 0);
    #2 RESET = 1'b1;
    repeat (40) @(negedge MCLK);
    chk("t5_no_fin", fin_cnt - f0, 0);
    DATA = 16'h1E00; push_txn(16'h1E00, -1); ENABLE = 1'b1;
    wait_busy(5); ENABLE = 1'b0;
    wait_fin(600);
    repeat (20) @(negedge MCLK);
    chk("t5_q_empty", exp_bytes.size(), 0);
    chk("fin_q_empty", exp_fin.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
